video_acc_sequencer: RTL and testbench

- Parametrised instruction sequencer for the video accelerator.
- Accepts 32-bit instructions from the bus-side BRAM controller into an internal FIFO and decodes meta (base-address load) and main (stream) opcodes.
- Issues source/dest/length commands to a read data mover and a write data mover, and drives the stream router destination for N_PORTS routes.
- Adds over the previous generation: exact occupancy readback, a configurable route count, and sticky illegal-opcode reporting.

---
 rtl/video_acc_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_video_acc_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_acc_sequencer.sv
// Instruction sequencer: buffers 32-bit instructions in a FIFO, decodes base loads and
// stream commands, and issues read/write mover commands. Optional perf counters: VIDEO_ACC_SEQ_PERF_EN.
module video_acc_sequencer #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DEST_WIDTH      = 3,
  parameter int N_PORTS         = 3,
  parameter int FIFO_DEPTH_LOG2 = 5,
  parameter int OFFSET_SHIFT    = 6
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       inst_wr_en,
  input  logic [31:0]                inst_wr_data,
  output logic [FIFO_DEPTH_LOG2:0]   inst_count,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [ADDR_WIDTH-1:0]      rd_len,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [DEST_WIDTH-1:0]      route_dest,
  output logic                       busy,
  output logic                       cmd_done,
  output logic                       err_illegal,
  input  logic                       err_clear,
`ifdef VIDEO_ACC_SEQ_PERF_EN
  output logic [31:0]                perf_busy_cycles,
  output logic [31:0]                perf_cmds,
`endif
  output logic [2:0]                 dbg_state
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_L = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [6:0] MAIN_END = 7'(8 + N_PORTS);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_HI_RD = 3'd1,
    S_LOAD_HI_WR = 3'd2,
    S_ISSUE      = 3'd3,
    S_RUN        = 3'd4
  } state_t;

  // Valid/ready: a command is transferred on any edge where valid && ready; valid then
  // drops the following cycle and the command registers stay frozen while valid is high.

  state_t                     r_state;
  logic [31:0]                r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic [ADDR_WIDTH-1:0]      r_base_rd;
  logic [ADDR_WIDTH-1:0]      r_base_wr;
  logic [ADDR_WIDTH-1:0]      r_rd_addr;
  logic [ADDR_WIDTH-1:0]      r_wr_addr;
  logic [ADDR_WIDTH-1:0]      r_rd_len;
  logic [DEST_WIDTH-1:0]      r_route_dest;
  logic                       r_rd_valid;
  logic                       r_wr_valid;
  logic                       r_cmd_done;
  logic                       r_err;

  logic                       w_empty;
  logic                       w_full;
  logic                       w_push;
  logic                       w_pop;
  logic [31:0]                w_head;
  logic [5:0]                 w_op;
  logic [5:0]                 w_k;
  logic                       w_is_main;
  logic                       w_is_meta;
  logic                       w_illegal;
  logic [ADDR_WIDTH-1:0]      w_src;
  logic [ADDR_WIDTH-1:0]      w_dst;
  logic [ADDR_WIDTH-1:0]      w_len;
  logic [ADDR_WIDTH+63:0]     w_hi_rd_ext;
  logic [ADDR_WIDTH+63:0]     w_hi_wr_ext;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_L);
  assign w_push    = inst_wr_en && !w_full;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_op      = w_head[5:0];
  assign w_k       = w_op - 6'd8;
  assign w_is_main = (w_op >= 6'd8) && ({1'b0, w_op} < MAIN_END);
  assign w_is_meta = (w_op == 6'd0) || (w_op == 6'd2) || (w_op == 6'd3) ||
                     (w_op == 6'd4) || (w_op == 6'd5);
  assign w_illegal = !w_is_main && !w_is_meta;
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || (r_state == S_LOAD_HI_RD) ||
                                  (r_state == S_LOAD_HI_WR));

  assign w_src = {{(ADDR_WIDTH-7){1'b0}}, w_head[12:6]}  << OFFSET_SHIFT;
  assign w_dst = {{(ADDR_WIDTH-7){1'b0}}, w_head[19:13]} << OFFSET_SHIFT;
  assign w_len = {{(ADDR_WIDTH-7){1'b0}}, w_head[26:20]} << OFFSET_SHIFT;

  // Upper-word loads land in bits [63:32]; the extension makes narrower buses truncate
  // and wider buses read zero above bit 63.
  assign w_hi_rd_ext = {{ADDR_WIDTH{1'b0}}, w_head, r_base_rd[31:0]};
  assign w_hi_wr_ext = {{ADDR_WIDTH{1'b0}}, w_head, r_base_wr[31:0]};

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= inst_wr_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_base_rd    <= '0;
      r_base_wr    <= '0;
      r_rd_addr    <= '0;
      r_wr_addr    <= '0;
      r_rd_len     <= '0;
      r_route_dest <= '0;
      r_rd_valid   <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_cmd_done   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_cmd_done <= 1'b0;
      if (err_clear)
        r_err <= 1'b0;
      else if (w_pop && (r_state == S_IDLE) && w_illegal)
        r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if ((w_op == 6'd2) || (w_op == 6'd4)) begin
              r_base_rd[31:6] <= w_head[31:6];
              if (w_op == 6'd2) r_state <= S_LOAD_HI_RD;
            end else if ((w_op == 6'd3) || (w_op == 6'd5)) begin
              r_base_wr[31:6] <= w_head[31:6];
              if (w_op == 6'd3) r_state <= S_LOAD_HI_WR;
            end else if (w_is_main && (w_len != '0)) begin
              r_rd_addr    <= r_base_rd + w_src;
              r_wr_addr    <= r_base_wr + w_dst;
              r_rd_len     <= w_len;
              r_route_dest <= DEST_WIDTH'(w_k);
              r_rd_valid   <= 1'b1;
              r_wr_valid   <= 1'b1;
              r_state      <= S_ISSUE;
            end
          end
        end
        S_LOAD_HI_RD: begin
          if (!w_empty) begin
            r_base_rd <= w_hi_rd_ext[ADDR_WIDTH-1:0];
            r_state   <= S_IDLE;
          end
        end
        S_LOAD_HI_WR: begin
          if (!w_empty) begin
            r_base_wr <= w_hi_wr_ext[ADDR_WIDTH-1:0];
            r_state   <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (r_rd_valid && rd_ready) r_rd_valid <= 1'b0;
          if (r_wr_valid && wr_ready) r_wr_valid <= 1'b0;
          if (!r_rd_valid && !r_wr_valid) r_state <= S_RUN;
        end
        S_RUN: begin
          if (rd_ready && wr_ready) begin
            r_cmd_done <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef VIDEO_ACC_SEQ_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_cmds;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_perf_busy <= '0;
      r_perf_cmds <= '0;
    end else begin
      if (((r_state == S_ISSUE) || (r_state == S_RUN)) && (r_perf_busy != 32'hFFFF_FFFF))
        r_perf_busy <= r_perf_busy + 32'd1;
      if (r_cmd_done) r_perf_cmds <= r_perf_cmds + 32'd1;
    end
  end

  assign perf_busy_cycles = r_perf_busy;
  assign perf_cmds        = r_perf_cmds;
`endif

  assign inst_count  = r_count;
  assign rd_addr     = r_rd_addr;
  assign rd_len      = r_rd_len;
  assign rd_valid    = r_rd_valid;
  assign wr_addr     = r_wr_addr;
  assign wr_valid    = r_wr_valid;
  assign route_dest  = r_route_dest;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign cmd_done    = r_cmd_done;
  assign err_illegal = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_video_acc_sequencer.sv
// Bench for video_acc_sequencer: directed scenarios plus random instruction bursts
// checked against an instruction-level model of the program's expected commands.
module tb_video_acc_sequencer;

  localparam int AW = 64;
  localparam int DW = 3;
  localparam int NP = 3;
  localparam int FL = 5;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          inst_wr_en = 1'b0;
  logic [31:0]   inst_wr_data = '0;
  logic [FL:0]   inst_count;
  logic [AW-1:0] rd_addr, rd_len, wr_addr;
  logic          rd_valid, wr_valid;
  logic          rd_ready = 1'b0;
  logic          wr_ready = 1'b0;
  logic [DW-1:0] route_dest;
  logic          busy, cmd_done, err_illegal;
  logic          err_clear = 1'b0;
  logic [2:0]    dbg_state;

  video_acc_sequencer #(
    .ADDR_WIDTH(AW), .DEST_WIDTH(DW), .N_PORTS(NP), .FIFO_DEPTH_LOG2(FL), .OFFSET_SHIFT(6)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .inst_wr_en(inst_wr_en), .inst_wr_data(inst_wr_data),
    .inst_count(inst_count), .rd_addr(rd_addr), .rd_len(rd_len), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .route_dest(route_dest), .busy(busy), .cmd_done(cmd_done), .err_illegal(err_illegal),
    .err_clear(err_clear), .dbg_state(dbg_state)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [63:0] ra;
    logic [63:0] wa;
    logic [63:0] ln;
    logic [2:0]  d;
  } cmd_t;

  cmd_t        exp_rd_q[$];
  cmd_t        exp_wr_q[$];
  cmd_t        mon_c;
  int          n_total = 0;
  int          n_bad = 0;
  int          exp_done = 0;
  int          act_done = 0;
  logic        rand_rdy = 1'b0;
  logic [63:0] m_base_rd = '0;
  logic [63:0] m_base_wr = '0;
  int          m_hi = 0;
  logic        m_err = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Program-level meaning of one accepted instruction word.
  task automatic model_word(input logic [31:0] w);
    logic [5:0]  op;
    logic [63:0] s, d, ln;
    cmd_t        c;
    op = w[5:0];
    s  = 64'(w[12:6])  << 6;
    d  = 64'(w[19:13]) << 6;
    ln = 64'(w[26:20]) << 6;
    if (m_hi == 1) begin
      m_base_rd = {w, m_base_rd[31:0]};
      m_hi = 0;
    end else if (m_hi == 2) begin
      m_base_wr = {w, m_base_wr[31:0]};
      m_hi = 0;
    end else if (op == 6'd0) begin
    end else if (op == 6'd2 || op == 6'd4) begin
      m_base_rd[31:6] = w[31:6];
      if (op == 6'd2) m_hi = 1;
    end else if (op == 6'd3 || op == 6'd5) begin
      m_base_wr[31:6] = w[31:6];
      if (op == 6'd3) m_hi = 2;
    end else if (op >= 6'd8 && int'(op) < 8 + NP) begin
      if (ln != 0) begin
        c.ra = m_base_rd + s;
        c.wa = m_base_wr + d;
        c.ln = ln;
        c.d  = 3'(op - 6'd8);
        exp_rd_q.push_back(c);
        exp_wr_q.push_back(c);
        exp_done++;
      end
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rand_rdy) begin
      rd_ready = ($urandom_range(0, 3) != 0);
      wr_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wr_word(input logic [31:0] w, input bit acc);
    inst_wr_en   = 1'b1;
    inst_wr_data = w;
    tick();
    inst_wr_en   = 1'b0;
    if (acc) model_word(w);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (!busy && exp_rd_q.size() == 0 && exp_wr_q.size() == 0) break;
    end
    tick();
    tick();
    check_eq(tag, 64'(busy), 64'd0);
  endtask

  task automatic wait_rd_valid(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (rd_valid) break;
    end
    check_eq(tag, 64'(rd_valid), 64'd1);
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (cmd_done) act_done++;
      if (rd_valid && rd_ready) begin
        if (exp_rd_q.size() == 0) check_eq("rd_unexpected", 64'(rd_valid), 64'd0);
        else begin
          mon_c = exp_rd_q.pop_front();
          check_eq("rd_addr", rd_addr, mon_c.ra);
          check_eq("rd_len", rd_len, mon_c.ln);
          check_eq("rd_route", 64'(route_dest), 64'(mon_c.d));
        end
      end
      if (wr_valid && wr_ready) begin
        if (exp_wr_q.size() == 0) check_eq("wr_unexpected", 64'(wr_valid), 64'd0);
        else begin
          mon_c = exp_wr_q.pop_front();
          check_eq("wr_addr", wr_addr, mon_c.wa);
          check_eq("wr_route", 64'(route_dest), 64'(mon_c.d));
        end
      end
    end
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [5:0]  ill [5];
    ill[0] = 6'h01; ill[1] = 6'h06; ill[2] = 6'h07; ill[3] = 6'h3F; ill[4] = 6'h20;
    w = $urandom;
    case ($urandom_range(0, 9))
      0:          w = 32'h0;
      1:          w[5:0] = 6'(2 + $urandom_range(0, 3));
      7:          w[5:0] = 6'(8 + NP);
      8:          w[5:0] = ill[$urandom_range(0, 4)];
      default: begin
        w[5:0] = 6'(8 + $urandom_range(0, NP - 1));
        if ($urandom_range(0, 5) == 0) w[26:20] = 7'd0;
      end
    endcase
    return w;
  endfunction

  initial begin
    int blen;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_rd_valid", 64'(rd_valid), 0);
    check_eq("rst_wr_valid", 64'(wr_valid), 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_rd_len", rd_len, 0);
    check_eq("rst_route", 64'(route_dest), 0);
    check_eq("rst_count", 64'(inst_count), 0);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_done", 64'(cmd_done), 0);
    check_eq("rst_err", 64'(err_illegal), 0);
    check_eq("rst_state", 64'(dbg_state), 0);
    aresetn = 1'b1;
    tick();

    // Base load with upper word, then an out-of-range route opcode.
    rd_ready = 1'b1; wr_ready = 1'b1;
    wr_word(32'h0000_0102, 1'b1);
    wr_word(32'h0000_0001, 1'b1);
    wr_word(32'h0000_004D, 1'b1);
    wait_idle("idle_t1");
    check_eq("err_set", 64'(err_illegal), 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    m_err = 1'b0;
    @(negedge aclk);
    check_eq("err_cleared", 64'(err_illegal), 0);

    // Route-1 command with the read mover stalled.
    tick();
    rd_ready = 1'b0; wr_ready = 1'b1;
    wr_word(32'h0000_2005, 1'b1);
    wr_word(32'h0110_C049, 1'b1);
    wait_rd_valid("vld_t2");
    check_eq("t2_rd_addr", rd_addr, 64'h1_0000_0140);
    check_eq("t2_wr_addr", wr_addr, 64'h2180);
    check_eq("t2_len", rd_len, 64'h440);
    check_eq("t2_route", 64'(route_dest), 1);
    check_eq("t2_wr_valid", 64'(wr_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_eq("stall_rd_valid", 64'(rd_valid), 1);
      check_eq("stall_wr_valid", 64'(wr_valid), 0);
      check_eq("stall_rd_addr", rd_addr, 64'h1_0000_0140);
      check_eq("stall_done", 64'(cmd_done), 0);
    end
    tick();
    rd_ready = 1'b1;
    wait_idle("idle_t3");
    check_eq("done_t3", act_done, exp_done);

    // Overfill the FIFO behind a blocked command, then drain.
    rd_ready = 1'b0; wr_ready = 1'b0;
    wr_word(32'h0010_0008, 1'b1);
    wait_rd_valid("vld_t4");
    tick();
    for (int i = 0; i < 40; i++) wr_word(32'h0, i < 32);
    @(negedge aclk);
    check_eq("full_count", 64'(inst_count), 32);
    tick();
    rd_ready = 1'b1; wr_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (cmd_done) break;
    end
    check_eq("t4_done_seen", 64'(cmd_done), 1);
    check_eq("full_before_pop", 64'(inst_count), 32);
    inst_wr_en = 1'b1;
    inst_wr_data = 32'h0000_003F;
    @(posedge aclk);
    #1;
    inst_wr_en = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      @(negedge aclk);
      check_eq("drain_count", 64'(inst_count), 64'(i));
    end
    wait_idle("idle_t4");
    check_eq("dropped_absent", 64'(err_illegal), 0);

    // Illegal opcode retiring in the same cycle as err_clear.
    wr_word(32'h0000_003F, 1'b1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    m_err = 1'b0;
    @(negedge aclk);
    check_eq("clear_priority", 64'(err_illegal), 0);

    // Reset while a command sits in RUN with instructions queued.
    tick();
    rd_ready = 1'b0; wr_ready = 1'b0;
    wr_word(32'h0010_0008, 1'b1);
    wait_rd_valid("vld_t6");
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0; wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    tick();
    tick();
    wr_word(32'h0, 1'b1);
    wr_word(32'h0, 1'b1);
    wr_word(32'h0, 1'b1);
    check_eq("run_busy", 64'(busy), 1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_eq("ar_rd_valid", 64'(rd_valid), 0);
    check_eq("ar_wr_valid", 64'(wr_valid), 0);
    check_eq("ar_count", 64'(inst_count), 0);
    check_eq("ar_busy", 64'(busy), 0);
    check_eq("ar_rd_addr", rd_addr, 0);
    check_eq("ar_route", 64'(route_dest), 0);
    exp_done--;
    m_base_rd = '0; m_base_wr = '0; m_hi = 0; m_err = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    rd_ready = 1'b1; wr_ready = 1'b1;
    tick();
    wr_word(32'h0010_0008, 1'b1);
    wait_rd_valid("vld_t7");
    check_eq("t7_rd_addr", rd_addr, 0);
    check_eq("t7_wr_addr", wr_addr, 0);
    check_eq("t7_len", rd_len, 64'h40);
    check_eq("t7_route", 64'(route_dest), 0);
    wait_idle("idle_t7");
    check_eq("done_t7", act_done, exp_done);

    // Random instruction bursts with random mover backpressure.
    rand_rdy = 1'b1;
    for (int b = 0; b < 25; b++) begin
      blen = $urandom_range(1, 30);
      for (int j = 0; j < blen; j++) wr_word(rand_word(), 1'b1);
      if (m_hi != 0) wr_word($urandom, 1'b1);
      wait_idle("idle_rand");
      check_eq("rand_err", 64'(err_illegal), 64'(m_err));
      check_eq("rand_done", act_done, exp_done);
      if (m_err) begin
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        m_err = 1'b0;
      end
    end
    rand_rdy = 1'b0;
    check_eq("rd_q_left", 64'(exp_rd_q.size()), 0);
    check_eq("wr_q_left", 64'(exp_wr_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
